// File: rtl/rl02_pkg.sv
// rl02_pkg: shared state encodings, header layout and CRC step for the RL02 read/write paths
package rl02_pkg;
  typedef enum logic [2:0] {IDLE, HUNT, HDR0, HDR1, CRCW, CHECK, GAP} rl02State_e;
  localparam logic [15:0] RL02_CRC_POLY = 16'h8005;
  localparam int HDR_W = 16;
  localparam int SECT_LSB = 0;
  localparam int HEAD_BIT = 6;
  localparam int CYL_LSB = 7;
  function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? RL02_CRC_POLY : 16'h0);
  endfunction
endpackage

// File: rtl/rl02_crc16_serial.sv
// rl02_crc16_serial: bit-serial CRC-16 (poly 0x8005), one update per enabled clk
module rl02_crc16_serial
  import rl02_pkg::*;
#(
  parameter logic [15:0] INIT = 16'h0
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  always_ff @(posedge clk) begin
    if (clear) crc <= INIT;
    else if (en) crc <= crcStep(crc, din);
  end
endmodule

// File: rtl/rl02_header_decoder.sv
// rl02_header_decoder: locates RL02 sector headers in the read stream and times the write gap
module rl02_header_decoder
  import rl02_pkg::*;
#(
  parameter int          PREAMBLE_MIN   = 32,
  parameter int          WRITE_GAP_BITS = 40,
  parameter logic [15:0] CRC_INIT       = 16'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read_bit,
  input  logic       read_bit_stb,
  input  logic       sector_pulse,
  input  logic       inhibit_read,
  output logic [5:0] sectorNum,
  output logic       headNum,
  output logic [8:0] cylNum,
  output logic       sectorNumReady,
  output logic       headNumReady,
  output logic       cylNumReady,
  output logic       beginWriteNow,
  output logic       crc_error,
  output logic [7:0] hdr_err_count
);
  localparam int GW = $clog2(WRITE_GAP_BITS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(WRITE_GAP_BITS - 1);
  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
  rl02State_e state, nextState;
  logic spPrev, spFall, lock, crcEn, wordEnd, good, zeroErr;
  logic [3:0] bitCnt;
  logic [5:0] zeroRun;
  logic [HDR_W-1:0] hdrSr, crcRx;
  logic [GW-1:0] gapCnt;
  logic [15:0] crc;
  assign spFall = spPrev & ~sector_pulse;
  assign wordEnd = read_bit_stb && bitCnt == 4'd15;
  assign good = crcRx == crc && !zeroErr;
  rl02_crc16_serial #(.INIT(CRC_INIT)) u_crc (
    .clk(clk), .clear(!rst || lock), .en(crcEn), .din(read_bit), .crc(crc)
  );
  always_comb begin
    nextState = state;
    lock = 1'b0;
    crcEn = 1'b0;
    if (inhibit_read) nextState = IDLE;
    else if (spFall) nextState = HUNT;
    else case (state)
      HUNT: begin
        lock = read_bit_stb && read_bit && zeroRun >= PRE_MIN;
        nextState = lock ? HDR0 : HUNT;
      end
      HDR0: begin
        crcEn = read_bit_stb;
        nextState = wordEnd ? HDR1 : HDR0;
      end
      HDR1: begin
        crcEn = read_bit_stb;
        nextState = wordEnd ? CRCW : HDR1;
      end
      CRCW: nextState = wordEnd ? CHECK : CRCW;
      CHECK: nextState = good ? GAP : IDLE;
      GAP: nextState = (read_bit_stb && gapCnt == GAP_LAST) ? IDLE : GAP;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      spPrev <= 1'b0;
      bitCnt <= '0;
      zeroRun <= '0;
      hdrSr <= '0;
      crcRx <= '0;
      zeroErr <= 1'b0;
      gapCnt <= '0;
      sectorNum <= '0;
      headNum <= 1'b0;
      cylNum <= '0;
      {sectorNumReady, headNumReady, cylNumReady} <= 3'b000;
      beginWriteNow <= 1'b0;
      crc_error <= 1'b0;
      hdr_err_count <= '0;
    end else begin
      spPrev <= sector_pulse;
      beginWriteNow <= 1'b0;
      crc_error <= 1'b0;
      if (inhibit_read || spFall) begin
        {sectorNumReady, headNumReady, cylNumReady} <= 3'b000;
        bitCnt <= '0;
        zeroRun <= '0;
      end else case (state)
        HUNT: if (read_bit_stb) begin
          zeroRun <= read_bit ? 6'd0 : (zeroRun == 6'd63 ? zeroRun : zeroRun + 6'd1);
          if (lock) zeroErr <= 1'b0;
        end
        HDR0: if (read_bit_stb) begin
          hdrSr <= {read_bit, hdrSr[HDR_W-1:1]};
          bitCnt <= bitCnt + 4'd1;
        end
        HDR1: if (read_bit_stb) begin
          zeroErr <= zeroErr | read_bit;
          bitCnt <= bitCnt + 4'd1;
        end
        CRCW: if (read_bit_stb) begin
          crcRx <= {read_bit, crcRx[HDR_W-1:1]};
          bitCnt <= bitCnt + 4'd1;
        end
        CHECK: if (good) begin
          sectorNum <= hdrSr[SECT_LSB +: 6];
          headNum <= hdrSr[HEAD_BIT];
          cylNum <= hdrSr[CYL_LSB +: 9];
          {sectorNumReady, headNumReady, cylNumReady} <= 3'b111;
          gapCnt <= '0;
        end else begin
          crc_error <= 1'b1;
          hdr_err_count <= hdr_err_count == 8'hFF ? hdr_err_count : hdr_err_count + 8'd1;
        end
        GAP: if (read_bit_stb) begin
          gapCnt <= gapCnt + GW'(1);
          beginWriteNow <= gapCnt == GAP_LAST;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rl02_header_decoder.sv
// tb_rl02_header_decoder: randomized self-checking bench against a polynomial-division header model
module tb_rl02_header_decoder;
  localparam int GAP_BITS = 40;
  logic clk = 0, rst = 0, read_bit = 0, read_bit_stb = 0, sector_pulse = 0, inhibit_read = 0;
  logic [5:0] sectorNum;
  logic headNum;
  logic [8:0] cylNum;
  logic sectorNumReady, headNumReady, cylNumReady, beginWriteNow, crc_error;
  logic [7:0] hdr_err_count;
  logic [18:0] got;
  logic [28:0] outs;
  int tests = 0, fails = 0, errModel = 0, bwnSeen = 0, errSeen = 0;
  logic bq[$];

  rl02_header_decoder dut (
    .clk(clk), .rst(rst), .read_bit(read_bit), .read_bit_stb(read_bit_stb),
    .sector_pulse(sector_pulse), .inhibit_read(inhibit_read),
    .sectorNum(sectorNum), .headNum(headNum), .cylNum(cylNum),
    .sectorNumReady(sectorNumReady), .headNumReady(headNumReady), .cylNumReady(cylNumReady),
    .beginWriteNow(beginWriteNow), .crc_error(crc_error), .hdr_err_count(hdr_err_count)
  );

  always #5 clk = ~clk;
  assign got = {sectorNumReady, headNumReady, cylNumReady, sectorNum, headNum, cylNum};
  assign outs = {sectorNum, headNum, cylNum, sectorNumReady, headNumReady, cylNumReady,
                 beginWriteNow, crc_error, hdr_err_count};

  always @(posedge clk) begin
    #1;
    if (beginWriteNow) bwnSeen++;
    if (crc_error) errSeen++;
  end

  // CRC as the remainder of M(x)*x^16 mod P, first transmitted bit is the highest power
  function automatic logic [15:0] modelCrc(input logic [15:0] w0, input logic [15:0] w1);
    logic [47:0] m;
    logic [31:0] msg;
    msg = {w1, w0};
    m = '0;
    for (int i = 0; i < 32; i++) m[47 - i] = msg[i];
    for (int k = 47; k >= 16; k--) if (m[k]) m[k -: 17] = m[k -: 17] ^ 17'h18005;
    return m[15:0];
  endfunction

  function automatic logic [18:0] fieldsOf(input logic [15:0] w);
    return {3'b111, 6'(w % 64), 1'((w / 64) % 2), 9'(w / 128)};
  endfunction

  function automatic logic [7:0] satErr();
    return errModel > 255 ? 8'd255 : 8'(errModel);
  endfunction

  task automatic addWord(input logic [15:0] w);
    for (int i = 0; i < 16; i++) bq.push_back(w[i]);
  endtask

  task automatic sendQ();
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      read_bit = bq[i];
      read_bit_stb = 1;
    end
    @(negedge clk);
    read_bit_stb = 0;
    bq.delete();
  endtask

  task automatic sendBit(input logic b);
    @(negedge clk);
    read_bit = b;
    read_bit_stb = 1;
    @(negedge clk);
    read_bit_stb = 0;
  endtask

  task automatic pulseSector();
    @(negedge clk);
    sector_pulse = 1;
    repeat (2) @(negedge clk);
    sector_pulse = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input int pre, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] x);
    bq.delete();
    repeat (pre) bq.push_back(1'b0);
    bq.push_back(1'b1);
    addWord(w0);
    addWord(w1);
    addWord(modelCrc(w0, w1) ^ x);
    pulseSector();
    sendQ();
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (outs !== '0) $display("FAIL reset_outputs got %h exp 0", outs);
    rst = 1;
  endtask

  task automatic test_good_header();
    int b0, e0;
    b0 = bwnSeen;
    e0 = errSeen;
    frame(40, 16'h0A85, 16'h0000, 16'h0000);
    @(negedge clk);
    tests++;
    if (got !== fieldsOf(16'h0A85)) begin fails++; $display("FAIL good_fields got %h exp %h", got, fieldsOf(16'h0A85)); end
    for (int k = 1; k <= GAP_BITS; k++) begin
      sendBit(1'($urandom));
      tests++;
      if (beginWriteNow !== 1'(k == GAP_BITS)) begin fails++; $display("FAIL gap_pulse strobe %0d got %b exp %b", k, beginWriteNow, k == GAP_BITS); end
    end
    @(negedge clk);
    tests++;
    if (beginWriteNow !== 1'b0 || bwnSeen - b0 != 1) begin fails++; $display("FAIL gap_width bwn %b pulses %0d exp 0/1", beginWriteNow, bwnSeen - b0); end
    tests++;
    if (got[18:16] !== 3'b111 || errSeen != e0) begin fails++; $display("FAIL ready_hold ready %b errs %0d exp 111/0", got[18:16], errSeen - e0); end
  endtask

  task automatic test_crc_error();
    int b0, e0;
    b0 = bwnSeen;
    e0 = errSeen;
    frame(40, 16'h0A85, 16'h0000, 16'h0008);
    errModel++;
    @(negedge clk);
    tests++;
    if (crc_error !== 1'b1 || got[18:16] !== 3'b000) begin fails++; $display("FAIL crcerr_pulse err %b ready %b exp 1/000", crc_error, got[18:16]); end
    tests++;
    if (hdr_err_count !== satErr()) begin fails++; $display("FAIL crcerr_count got %0d exp %0d", hdr_err_count, satErr()); end
    repeat (GAP_BITS + 5) sendBit(1'($urandom));
    tests++;
    if (errSeen - e0 != 1 || bwnSeen != b0) begin fails++; $display("FAIL crcerr_after errs %0d bwn %0d exp 1/0", errSeen - e0, bwnSeen - b0); end
  endtask

  task automatic test_short_preamble();
    logic [15:0] w;
    int e0;
    w = 16'($urandom);
    repeat (20) bq.push_back(1'b0);
    bq.push_back(1'b1);
    repeat (32) bq.push_back(1'b0);
    bq.push_back(1'b1);
    addWord(w);
    addWord(16'h0000);
    addWord(modelCrc(w, 16'h0000));
    pulseSector();
    sendQ();
    @(negedge clk);
    tests++;
    if (got !== fieldsOf(w)) begin fails++; $display("FAIL short_then_lock got %h exp %h", got, fieldsOf(w)); end
    e0 = errSeen;
    frame(31, 16'h8A85, 16'h0000, 16'h0000);
    repeat (4) @(negedge clk);
    tests++;
    if (got[18:16] !== 3'b000 || errSeen != e0) begin fails++; $display("FAIL pre31_nolock ready %b errs %0d exp 000/0", got[18:16], errSeen - e0); end
  endtask

  task automatic test_inhibit();
    logic [15:0] w;
    int b0, e0;
    b0 = bwnSeen;
    e0 = errSeen;
    w = 16'($urandom);
    repeat (40) bq.push_back(1'b0);
    bq.push_back(1'b1);
    for (int i = 0; i < 8; i++) bq.push_back(w[i]);
    pulseSector();
    sendQ();
    inhibit_read = 1;
    @(negedge clk);
    tests++;
    if ({got[18:16], beginWriteNow, crc_error} !== 5'b0) begin fails++; $display("FAIL inhibit_hdr0 got %b exp 0", {got[18:16], beginWriteNow, crc_error}); end
    inhibit_read = 0;
    for (int i = 8; i < 16; i++) bq.push_back(w[i]);
    addWord(16'h0000);
    addWord(modelCrc(w, 16'h0000));
    sendQ();
    repeat (3) @(negedge clk);
    tests++;
    if (got[18:16] !== 3'b000 || errSeen != e0) begin fails++; $display("FAIL inhibit_tail ready %b errs %0d exp 000/0", got[18:16], errSeen - e0); end
    frame(40, w, 16'h0000, 16'h0000);
    @(negedge clk);
    tests++;
    if (got !== fieldsOf(w)) begin fails++; $display("FAIL inhibit_recover got %h exp %h", got, fieldsOf(w)); end
    repeat (5) sendBit(1'($urandom));
    inhibit_read = 1;
    @(negedge clk);
    tests++;
    if (got[18:16] !== 3'b000) begin fails++; $display("FAIL inhibit_gap ready %b exp 000", got[18:16]); end
    inhibit_read = 0;
    repeat (GAP_BITS + 5) sendBit(1'($urandom));
    tests++;
    if (bwnSeen != b0 || got[18:16] !== 3'b000) begin fails++; $display("FAIL inhibit_nowrite bwn %0d ready %b exp 0/000", bwnSeen - b0, got[18:16]); end
  endtask

  task automatic test_zero_word();
    logic [15:0] w;
    w = 16'($urandom);
    frame(40, w, 16'h0001, 16'h0000);
    errModel++;
    @(negedge clk);
    tests++;
    if (crc_error !== 1'b1 || got[18:16] !== 3'b000 || hdr_err_count !== satErr()) begin
      fails++;
      $display("FAIL zero_word err %b ready %b count %0d exp 1/000/%0d", crc_error, got[18:16], hdr_err_count, satErr());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [15:0] w0, w1, x;
      logic goodE;
      w0 = 16'($urandom);
      w1 = $urandom_range(3) == 0 ? 16'(1 << $urandom_range(15)) : 16'h0;
      x = $urandom_range(2) == 0 ? 16'(1 << $urandom_range(15)) : 16'h0;
      goodE = w1 == 0 && x == 0;
      frame($urandom_range(45, 32), w0, w1, x);
      if (!goodE) errModel++;
      @(negedge clk);
      tests++;
      if (crc_error !== !goodE) begin fails++; $display("FAIL rand_err[%0d] got %b exp %b", n, crc_error, !goodE); end
      tests++;
      if (goodE ? got !== fieldsOf(w0) : got[18:16] !== 3'b000) begin fails++; $display("FAIL rand_fields[%0d] got %h good %b w0 %h", n, got, goodE, w0); end
      tests++;
      if (hdr_err_count !== satErr()) begin fails++; $display("FAIL rand_count[%0d] got %0d exp %0d", n, hdr_err_count, satErr()); end
    end
  endtask

  task automatic test_saturate_and_reset();
    int e0;
    e0 = errSeen;
    repeat (300) begin
      frame(32, 16'($urandom), 16'h0000, 16'h0001);
      errModel++;
    end
    @(negedge clk);
    tests++;
    if (hdr_err_count !== 8'd255 || errSeen - e0 != 300) begin fails++; $display("FAIL saturate count %0d pulses %0d exp 255/300", hdr_err_count, errSeen - e0); end
    frame(40, 16'hB5A3, 16'h0000, 16'h0000);
    @(negedge clk);
    tests++;
    if (got !== fieldsOf(16'hB5A3) || hdr_err_count !== satErr()) begin fails++; $display("FAIL sat_good got %h count %0d exp %h/%0d", got, hdr_err_count, fieldsOf(16'hB5A3), satErr()); end
    rst = 0;
    @(negedge clk);
    rst = 1;
    errModel = 0;
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL rst_clears got %h exp 0", outs); end
    repeat (3) @(negedge clk);
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL rst_holds got %h exp 0", outs); end
  endtask

  initial begin
    test_reset();
    if (outs !== '0) fails++;
    test_good_header();
    test_crc_error();
    test_short_preamble();
    test_inhibit();
    test_zero_word();
    test_random();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
